// File: rtl/store_buffer.sv
// store_buffer: a FIFO store buffer between the pipeline and data memory.
// Each accepted store is aligned into a word-address, byte-lane data and
// byte-enable entry. Entries retire to memory in order, one per mem_ack.
//
// Ports:
//   clk, rst_b      - clock, synchronous active-low reset
//   st_valid/st_sel - store request and size (00 none, 01 SB, 10 SH, 11 SW)
//   st_addr/st_data - store byte address and unaligned register data
//   st_ready        - buffer can take a store this cycle
//   st_misalign     - one-cycle pulse after a misaligned store is rejected
//   drain, empty    - block new stores until the buffer is empty; no entries pending
//   mem_req/addr/wdata/be, mem_ack - memory write port with head-entry handshake
//   ld_addr, ld_hazard - MEM-stage load address; asserted if the load word matches a pending store
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        st_valid,
  input  logic [1:0]  st_sel,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_misalign,
  input  logic        drain,
  output logic        empty,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [PW:0]     count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            drain_q, drain_d;
  logic            misalign_q, misalign_d;

  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [3:0]      be_q   [DEPTH];

  logic [31:0]     ent_addr_d, ent_data_d;
  logic [3:0]      ent_be_d;
  logic            st_req, aligned, drain_active, push, pop;
  logic [1:0]      unused_ld_lo;

  assign unused_ld_lo = ld_addr[1:0];

  // Store acceptance and entry formation
  always_comb begin
    st_req       = st_valid & (st_sel != 2'b00);
    empty        = (count_q == '0);
    // A drain request stays sticky until the buffer is seen empty.
    drain_active = (drain | drain_q) & ~empty;
    drain_d      = drain_active;
    st_ready     = rst_b & (count_q < FULL_CNT) & ~drain_active;

    unique case (st_sel)
      2'b10:   aligned = ~st_addr[0];
      2'b11:   aligned = (st_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    push       = st_req & st_ready & aligned;
    misalign_d = st_req & st_ready & ~aligned;
    pop        = (state_q == BUSY) & mem_ack;

    ent_addr_d = {st_addr[31:2], 2'b00};
    ent_data_d = st_data << {st_addr[1:0], 3'b000};
    unique case (st_sel)
      2'b01:   ent_be_d = 4'b0001 << st_addr[1:0];
      2'b10:   ent_be_d = 4'b0011 << st_addr[1:0];
      default: ent_be_d = 4'b1111;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Controller next state; looking at count_d lets mem_req rise the cycle
  // after the first push and keeps BUSY through back-to-back push/pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (count_d != '0) state_d = BUSY;
      BUSY: if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (state_q == BUSY) begin
      mem_req   = 1'b1;
      mem_addr  = addr_q[rd_ptr_q];
      mem_wdata = data_q[rd_ptr_q];
      mem_be    = be_q[rd_ptr_q];
    end
  end

  // Load hazard scans entries from the head forward; a store being accepted
  // this cycle is not yet counted.
  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count_q) &&
          (addr_q[rd_ptr_q + PW'(i)][31:2] == ld_addr[31:2]))
        ld_hazard = 1'b1;
    end
  end

  assign st_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drain_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drain_q    <= drain_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= ent_addr_d;
      data_q[wr_ptr_q] <= ent_data_d;
      be_q[wr_ptr_q]   <= ent_be_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized self-checking bench for store_buffer against a queue-based model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam logic [1:0] SB = 2'b01, SH = 2'b10, SW = 2'b11;

  logic        clk = 1'b0;
  logic        rst_b, st_valid, st_ready, st_misalign, drain, empty;
  logic [1:0]  st_sel;
  logic [31:0] st_addr, st_data, mem_addr, mem_wdata, ld_addr;
  logic        mem_req, mem_ack, ld_hazard;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t mdl_q[$];
  bit   mdl_drain = 1'b0;
  bit   mdl_mis   = 1'b0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .st_valid(st_valid), .st_sel(st_sel),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .st_misalign(st_misalign), .drain(drain), .empty(empty),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .ld_addr(ld_addr),
    .ld_hazard(ld_hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mdl_drain_act();
    return (drain || mdl_drain) && (mdl_q.size() != 0);
  endfunction

  function automatic bit mdl_ready();
    return rst_b && (mdl_q.size() < DEPTH) && !mdl_drain_act();
  endfunction

  task automatic compare_all();
    bit haz = 1'b0;
    foreach (mdl_q[i])
      if (mdl_q[i].addr[31:2] == ld_addr[31:2]) haz = 1'b1;
    check("st_ready", 32'(st_ready), 32'(mdl_ready()));
    check("st_misalign", 32'(st_misalign), 32'(mdl_mis));
    check("empty", 32'(empty), 32'(mdl_q.size() == 0));
    check("mem_req", 32'(mem_req), 32'(mdl_q.size() != 0));
    check("ld_hazard", 32'(ld_hazard), 32'(haz));
    if (mdl_q.size() != 0) begin
      check("mem_addr", mem_addr, mdl_q[0].addr);
      check("mem_wdata", mem_wdata, mdl_q[0].data);
      check("mem_be", 32'(mem_be), 32'(mdl_q[0].be));
    end else begin
      check("mem_addr_idle", mem_addr, 32'h0);
      check("mem_wdata_idle", mem_wdata, 32'h0);
      check("mem_be_idle", 32'(mem_be), 32'h0);
    end
  endtask

  task automatic model_update();
    bit req, ok, rdy, dact, pop;
    int off;
    ent_t e;
    if (!rst_b) begin
      mdl_q.delete();
      mdl_drain = 1'b0;
      mdl_mis   = 1'b0;
    end else begin
      dact = mdl_drain_act();
      rdy  = mdl_ready();
      req  = st_valid && (st_sel != 2'b00);
      ok   = (st_sel == SB) || (st_sel == SH && st_addr[0] == 1'b0) ||
             (st_sel == SW && st_addr[1:0] == 2'b00);
      pop  = (mdl_q.size() != 0) && mem_ack;
      mdl_mis   = req && rdy && !ok;
      mdl_drain = dact;
      if (pop) void'(mdl_q.pop_front());
      if (req && rdy && ok) begin
        off    = int'(st_addr[1:0]);
        e.addr = {st_addr[31:2], 2'b00};
        e.data = st_data << (8 * off);
        e.be   = (st_sel == SB) ? (4'b0001 << off) :
                 (st_sel == SH) ? (4'b0011 << off) : 4'b1111;
        mdl_q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic push_one(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_sel = sel; st_addr = a; st_data = d;
    step();
    st_valid = 1'b0; st_sel = 2'b00;
  endtask

  initial begin
    rst_b = 1'b0; st_valid = 1'b0; st_sel = 2'b00; st_addr = '0; st_data = '0;
    drain = 1'b0; mem_ack = 1'b0; ld_addr = '0;

    // Reset
    @(posedge clk); #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_ld_hazard", 32'(ld_hazard), 32'h0);
    check("rst_st_ready", 32'(st_ready), 32'h0);
    check("rst_misalign", 32'(st_misalign), 32'h0);
    step();
    rst_b = 1'b1; #1;
    check("rel_st_ready", 32'(st_ready), 32'h1);

    // SB to 0x1003
    push_one(SB, 32'h1003, 32'h0000_00AB);
    check("sb_req", 32'(mem_req), 32'h1);
    check("sb_addr", mem_addr, 32'h1000);
    check("sb_wdata", mem_wdata, 32'hAB00_0000);
    check("sb_be", 32'(mem_be), 32'h8);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;

    // SH aligned and misaligned
    push_one(SH, 32'h2002, 32'h1234_CDEF);
    check("sh_wdata", mem_wdata, 32'hCDEF_0000);
    check("sh_be", 32'(mem_be), 32'hC);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    push_one(SH, 32'h2001, 32'h1234_CDEF);
    check("mis_pulse", 32'(st_misalign), 32'h1);
    check("mis_empty", 32'(empty), 32'h1);
    step();
    check("mis_clear", 32'(st_misalign), 32'h0);

    // Full buffer, held 5th store, pop in order
    for (int i = 0; i < 4; i++) push_one(SW, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    check("full_ready", 32'(st_ready), 32'h0);
    st_valid = 1'b1; st_sel = SW; st_addr = 32'h110; st_data = 32'hA4;
    step();
    check("held_empty", 32'(empty), 32'h0);
    check("held_head", mem_addr, 32'h100);
    mem_ack = 1'b1; #1;
    check("full_pop_ready", 32'(st_ready), 32'h0);
    step(); mem_ack = 1'b0;
    check("pop_order", mem_addr, 32'h104);
    check("after_pop_ready", 32'(st_ready), 32'h1);
    step(); st_valid = 1'b0; st_sel = 2'b00;
    check("refill_ready", 32'(st_ready), 32'h0);
    mem_ack = 1'b1; repeat (5) step(); mem_ack = 1'b0;
    check("flush_empty", 32'(empty), 32'h1);

    // Load hazard
    push_one(SW, 32'h3000, 32'h5555_AAAA);
    ld_addr = 32'h3002; #1;
    check("haz_same_word", 32'(ld_hazard), 32'h1);
    ld_addr = 32'h3004; #1;
    check("haz_next_word", 32'(ld_hazard), 32'h0);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    ld_addr = 32'h3002; #1;
    check("haz_after_ack", 32'(ld_hazard), 32'h0);

    // Drain
    push_one(SW, 32'h600, 32'h1);
    push_one(SW, 32'h604, 32'h2);
    drain = 1'b1; #1;
    check("drain_block", 32'(st_ready), 32'h0);
    step(); drain = 1'b0; #1;
    check("drain_sticky", 32'(st_ready), 32'h0);
    mem_ack = 1'b1; step();
    check("drain_one_left", 32'(st_ready), 32'h0);
    step(); mem_ack = 1'b0;
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_released", 32'(st_ready), 32'h1);

    // Reset during BUSY, then late ack
    for (int i = 0; i < 3; i++) push_one(SW, 32'h500 + 32'(4 * i), 32'(i));
    rst_b = 1'b0; step();
    check("midrst_req", 32'(mem_req), 32'h0);
    check("midrst_empty", 32'(empty), 32'h1);
    rst_b = 1'b1; mem_ack = 1'b1; step(); mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'h0);
    check("late_ack_empty", 32'(empty), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst_b    = ($urandom_range(0, 99) != 0);
      st_valid = ($urandom_range(0, 3) != 0);
      st_sel   = 2'($urandom_range(0, 3));
      st_addr  = 32'h4000 + 32'($urandom_range(0, 31));
      st_data  = $urandom();
      mem_ack  = ($urandom_range(0, 9) < 6);
      drain    = ($urandom_range(0, 19) == 0);
      ld_addr  = 32'h4000 + 32'($urandom_range(0, 35));
      step();
    end

    rst_b = 1'b1; st_valid = 1'b0; st_sel = 2'b00; drain = 1'b0; mem_ack = 1'b1;
    repeat (DEPTH + 2) step();
    check("final_empty", 32'(empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
